// File: rtl/shared_rand_gen.sv
// Fresh-randomness source for DOM-masked GF(2^2) multipliers: seeded 32-bit
// Fibonacci LFSR unrolled ZW steps per cycle, with seed handshake, warm-up and reseed request.
module shared_rand_gen #(
  parameter  int SHARES          = 3,
  parameter  int WARMUP          = 64,
  parameter  int RESEED_INTERVAL = 1024,
  localparam int ZW              = SHARES * (SHARES - 1)
) (
  input  logic          ClkxCI,
  input  logic          RstxBI,
  input  logic [31:0]   SeedxDI,
  input  logic          SeedValidxSI,
  output logic          SeedReadyxSO,
  input  logic          EnxSI,
  output logic [ZW-1:0] _ZxDO,
  output logic          ValidxSO,
  output logic          ReseedReqxSO
);

  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int OCW = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WARM, ST_RUN} state_e;

  state_e         state_q;
  logic [31:0]    lfsr_q, lfsr_d, seed_fix;
  logic [ZW-1:0]  z_q, fb_d;
  logic [WCW-1:0] wcnt_q;
  logic [OCW-1:0] ocnt_q, ocnt_d;
  logic           valid_q, req_q, xfer;

  // ZW chained steps; each step's feedback bit is also an output bit
  always_comb begin
    lfsr_d = lfsr_q;
    fb_d   = '0;
    for (int i = 0; i < ZW; i++) begin
      fb_d[i] = lfsr_d[31] ^ lfsr_d[21] ^ lfsr_d[1] ^ lfsr_d[0];
      lfsr_d  = {lfsr_d[30:0], fb_d[i]};
    end
  end

  assign SeedReadyxSO = (state_q != ST_WARM);
  assign xfer         = SeedValidxSI & SeedReadyxSO;
  assign seed_fix     = (SeedxDI == 32'h0) ? 32'h1 : SeedxDI;
  assign ocnt_d       = (ocnt_q == OCW'(RESEED_INTERVAL)) ? ocnt_q : ocnt_q + 1'b1;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      wcnt_q  <= '0;
      ocnt_q  <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else if (xfer) begin
      // seed beats EnxSI; the accepting cycle produces no output
      lfsr_q  <= seed_fix;
      wcnt_q  <= WCW'(WARMUP);
      ocnt_q  <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      state_q <= (WARMUP == 0) ? ST_RUN : ST_WARM;
    end else begin
      case (state_q)
        ST_WARM: begin
          lfsr_q <= lfsr_d;
          wcnt_q <= wcnt_q - 1'b1;
          if (wcnt_q == WCW'(1)) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (EnxSI) begin
            lfsr_q  <= lfsr_d;
            z_q     <= fb_d;
            valid_q <= 1'b1;
            ocnt_q  <= ocnt_d;
            if (RESEED_INTERVAL != 0 && ocnt_d == OCW'(RESEED_INTERVAL)) req_q <= 1'b1;
          end
        end
        ST_IDLE: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign _ZxDO        = z_q;
  assign ValidxSO     = valid_q;
  assign ReseedReqxSO = req_q;

endmodule
